// File: rtl/ex_mem_reg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg_pkg
// Purpose  : Shared pipeline definitions for the EX/MEM boundary: datapath
//            width, MEM-side sequencer state encoding and the packed bundle
//            of EX results that the pipeline register carries.
// Revision : 1.0  initial release
// ============================================================================
package ex_mem_reg_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 2;
  localparam int REG_W  = 3;

  // MEM-side sequencer: IDLE captures, ISSUE strobes memory once, WAIT holds
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_state_e;

  // Everything EX hands to MEM, packed so one register instance holds it
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] pc_add2;
    logic [DATA_W-1:0] pc_imm_add;
    logic              msb;
    logic              zero;
    logic              dmem_en;
    logic              dmem_write;
    logic              dmem_dump;
    logic              pc_imm;
    logic              pc_src;
    logic              jump;
    logic              reg_write;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  write_reg;
  } ex_fields_t;

  localparam int FIELDS_W = $bits(ex_fields_t);

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg_if
// Purpose  : EX/MEM boundary bundle: EX results in, data-memory handshake in,
//            MEM-stage copies, memory strobes and pipeline stall out.
//            master = pipeline/memory side, slave = the EX/MEM register.
// Revision : 1.0  initial release
// ============================================================================
interface ex_mem_reg_if;
  import ex_mem_reg_pkg::*;

  // EX side
  logic              ex_valid;
  logic              flush;
  logic [DATA_W-1:0] ex_ALU_Out;
  logic [DATA_W-1:0] ex_readData2;
  logic [DATA_W-1:0] ex_PCAdd2;
  logic [DATA_W-1:0] ex_PCImmAdd;
  logic              ex_MSB;
  logic              ex_Zero;
  logic              ex_DMemEn;
  logic              ex_DMemWrite;
  logic              ex_DMemDump;
  logic              ex_PCImm;
  logic              ex_PCSrc;
  logic              ex_Jump;
  logic              ex_RegWrite;
  logic [OPC_W-1:0]  ex_OpCode1_0;
  logic [REG_W-1:0]  ex_WriteReg;

  // Data memory side
  logic              dmem_stall;
  logic              dmem_done;
  logic [DATA_W-1:0] dmem_data;

  // MEM side
  logic [DATA_W-1:0] mem_ALU_Out;
  logic [DATA_W-1:0] mem_readData2;
  logic [DATA_W-1:0] mem_PCAdd2;
  logic [DATA_W-1:0] mem_PCImmAdd;
  logic              mem_MSB;
  logic              mem_Zero;
  logic              mem_DMemEn;
  logic              mem_DMemWrite;
  logic              mem_DMemDump;
  logic              mem_PCImm;
  logic              mem_PCSrc;
  logic              mem_Jump;
  logic              mem_RegWrite;
  logic [OPC_W-1:0]  mem_OpCode1_0;
  logic [REG_W-1:0]  mem_WriteReg;
  logic              mem_valid;
  logic              mem_Rd;
  logic              mem_Wr;
  logic [DATA_W-1:0] mem_load_data;
  logic              pipe_stall;

  modport master (
    output ex_valid, flush, ex_ALU_Out, ex_readData2, ex_PCAdd2, ex_PCImmAdd,
           ex_MSB, ex_Zero, ex_DMemEn, ex_DMemWrite, ex_DMemDump, ex_PCImm,
           ex_PCSrc, ex_Jump, ex_RegWrite, ex_OpCode1_0, ex_WriteReg,
           dmem_stall, dmem_done, dmem_data,
    input  mem_ALU_Out, mem_readData2, mem_PCAdd2, mem_PCImmAdd,
           mem_MSB, mem_Zero, mem_DMemEn, mem_DMemWrite, mem_DMemDump,
           mem_PCImm, mem_PCSrc, mem_Jump, mem_RegWrite, mem_OpCode1_0,
           mem_WriteReg, mem_valid, mem_Rd, mem_Wr, mem_load_data, pipe_stall
  );

  modport slave (
    input  ex_valid, flush, ex_ALU_Out, ex_readData2, ex_PCAdd2, ex_PCImmAdd,
           ex_MSB, ex_Zero, ex_DMemEn, ex_DMemWrite, ex_DMemDump, ex_PCImm,
           ex_PCSrc, ex_Jump, ex_RegWrite, ex_OpCode1_0, ex_WriteReg,
           dmem_stall, dmem_done, dmem_data,
    output mem_ALU_Out, mem_readData2, mem_PCAdd2, mem_PCImmAdd,
           mem_MSB, mem_Zero, mem_DMemEn, mem_DMemWrite, mem_DMemDump,
           mem_PCImm, mem_PCSrc, mem_Jump, mem_RegWrite, mem_OpCode1_0,
           mem_WriteReg, mem_valid, mem_Rd, mem_Wr, mem_load_data, pipe_stall
  );

endinterface

`default_nettype wire

// File: rtl/ex_mem_reg_reg_en.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reg_en
// Purpose  : Generic width register with synchronous active-high reset and
//            load enable; holds its value whenever the enable is low.
// Revision : 1.0  initial release
// ============================================================================
module reg_en #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Reset to zero, load on enable, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg
// Purpose  : EX/MEM pipeline register with a small memory sequencer. Captures
//            EX results while idle, issues a single read/write strobe for a
//            memory instruction, then stalls the front of the pipe until the
//            data memory reports completion.
// Revision : 1.0  initial release
// ============================================================================
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  ex_mem_reg_if.slave  bus
);

  mem_state_e        state_q;
  logic              rd_q;
  logic              wr_q;
  ex_fields_t        fields_d;
  ex_fields_t        fields_q;
  logic              valid_q;
  logic [DATA_W-1:0] load_q;

  logic w_capture;
  logic w_valid_d;
  logic w_mem_op_d;
  logic w_busy;
  logic w_read_out;
  logic w_load_en;

  // The register only advances while the sequencer is idle; a flushed
  // instruction enters MEM as a bubble and cannot start a memory access.
  assign w_capture  = (state_q == IDLE);
  assign w_valid_d  = bus.ex_valid & ~bus.flush;
  assign w_mem_op_d = w_valid_d & (bus.ex_DMemEn | bus.ex_DMemWrite);

  // An access is in flight from the strobe cycle until completion
  assign w_busy     = (state_q == ISSUE) || (state_q == WAIT);
  assign w_read_out = w_busy & fields_q.dmem_en & ~fields_q.dmem_write;
  assign w_load_en  = w_read_out & bus.dmem_done;

  // Stall drops in the completion cycle so the pipe restarts without a gap
  assign bus.pipe_stall = w_busy & ~bus.dmem_done;

  // Assemble next field values; bubbles never write the register file or dump
  always_comb begin
    fields_d            = '0;
    fields_d.alu_out    = bus.ex_ALU_Out;
    fields_d.read_data2 = bus.ex_readData2;
    fields_d.pc_add2    = bus.ex_PCAdd2;
    fields_d.pc_imm_add = bus.ex_PCImmAdd;
    fields_d.msb        = bus.ex_MSB;
    fields_d.zero       = bus.ex_Zero;
    fields_d.dmem_en    = bus.ex_DMemEn;
    fields_d.dmem_write = bus.ex_DMemWrite;
    fields_d.dmem_dump  = bus.ex_DMemDump & w_valid_d;
    fields_d.pc_imm     = bus.ex_PCImm;
    fields_d.pc_src     = bus.ex_PCSrc;
    fields_d.jump       = bus.ex_Jump;
    fields_d.reg_write  = bus.ex_RegWrite & w_valid_d;
    fields_d.opcode     = bus.ex_OpCode1_0;
    fields_d.write_reg  = bus.ex_WriteReg;
  end

  reg_en #(.WIDTH(FIELDS_W)) u_fields (
    .clk  (clk),
    .rst  (rst),
    .en_i (w_capture),
    .d_i  (fields_d),
    .q_o  (fields_q)
  );

  reg_en #(.WIDTH(1)) u_valid (
    .clk  (clk),
    .rst  (rst),
    .en_i (w_capture),
    .d_i  (w_valid_d),
    .q_o  (valid_q)
  );

  reg_en #(.WIDTH(DATA_W)) u_load (
    .clk  (clk),
    .rst  (rst),
    .en_i (w_load_en),
    .d_i  (bus.dmem_data),
    .q_o  (load_q)
  );

  // Sequencer: one strobe per memory instruction, then wait for completion.
  // Strobes are registered alongside the IDLE->ISSUE transition so they are
  // high exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_mem_op_d) begin
            state_q <= ISSUE;
            rd_q    <= bus.ex_DMemEn & ~bus.ex_DMemWrite;
            wr_q    <= bus.ex_DMemWrite;
          end
        end
        ISSUE:   state_q <= bus.dmem_done ? IDLE : WAIT;
        WAIT:    if (bus.dmem_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_ALU_Out   = fields_q.alu_out;
  assign bus.mem_readData2 = fields_q.read_data2;
  assign bus.mem_PCAdd2    = fields_q.pc_add2;
  assign bus.mem_PCImmAdd  = fields_q.pc_imm_add;
  assign bus.mem_MSB       = fields_q.msb;
  assign bus.mem_Zero      = fields_q.zero;
  assign bus.mem_DMemEn    = fields_q.dmem_en;
  assign bus.mem_DMemWrite = fields_q.dmem_write;
  assign bus.mem_DMemDump  = fields_q.dmem_dump;
  assign bus.mem_PCImm     = fields_q.pc_imm;
  assign bus.mem_PCSrc     = fields_q.pc_src;
  assign bus.mem_Jump      = fields_q.jump;
  assign bus.mem_RegWrite  = fields_q.reg_write;
  assign bus.mem_OpCode1_0 = fields_q.opcode;
  assign bus.mem_WriteReg  = fields_q.write_reg;
  assign bus.mem_valid     = valid_q;
  assign bus.mem_Rd        = rd_q;
  assign bus.mem_Wr        = wr_q;
  assign bus.mem_load_data = load_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_reg
// Purpose  : Self-checking bench for ex_mem_reg: directed scenarios with
//            literal expectations followed by randomized traffic, all checked
//            every cycle against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_reg;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   rd_count;

  ex_mem_reg_if bus();

  ex_mem_reg u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what MEM must hold: last accepted EX instruction, whether a
  // memory access is outstanding, and whether this is its strobe cycle.
  logic [15:0] m_alu, m_rd2, m_pc2, m_pci, m_load;
  logic [8:0]  m_flags;  // MSB,Zero,DMemEn,DMemWrite,DMemDump,PCImm,PCSrc,Jump,RegWrite
  logic [1:0]  m_opc;
  logic [2:0]  m_wreg;
  bit          m_valid, m_busy, m_first;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit v;
    if (rst) begin
      m_alu = 0; m_rd2 = 0; m_pc2 = 0; m_pci = 0; m_load = 0;
      m_flags = 0; m_opc = 0; m_wreg = 0;
      m_valid = 0; m_busy = 0; m_first = 0;
    end else if (!m_busy) begin
      v       = bus.ex_valid && !bus.flush;
      m_valid = v;
      m_alu   = bus.ex_ALU_Out;
      m_rd2   = bus.ex_readData2;
      m_pc2   = bus.ex_PCAdd2;
      m_pci   = bus.ex_PCImmAdd;
      m_flags = {bus.ex_MSB, bus.ex_Zero, bus.ex_DMemEn, bus.ex_DMemWrite,
                 bus.ex_DMemDump & v, bus.ex_PCImm, bus.ex_PCSrc, bus.ex_Jump,
                 bus.ex_RegWrite & v};
      m_opc   = bus.ex_OpCode1_0;
      m_wreg  = bus.ex_WriteReg;
      m_busy  = v && (bus.ex_DMemEn || bus.ex_DMemWrite);
      m_first = m_busy;
    end else begin
      m_first = 0;
      if (bus.dmem_done) begin
        if (m_flags[6] && !m_flags[5]) m_load = bus.dmem_data;
        m_busy = 0;
      end
    end
  endtask

  // Every cycle: advance the model on the edge, compare late in the cycle
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #8;
      if (bus.mem_Rd) rd_count++;
      chk("ALU_Out",   bus.mem_ALU_Out,   m_alu);
      chk("readData2", bus.mem_readData2, m_rd2);
      chk("PCAdd2",    bus.mem_PCAdd2,    m_pc2);
      chk("PCImmAdd",  bus.mem_PCImmAdd,  m_pci);
      chk("flags", {7'd0, bus.mem_MSB, bus.mem_Zero, bus.mem_DMemEn, bus.mem_DMemWrite,
                   bus.mem_DMemDump, bus.mem_PCImm, bus.mem_PCSrc, bus.mem_Jump,
                   bus.mem_RegWrite}, {7'd0, m_flags});
      chk("OpCode",    {14'd0, bus.mem_OpCode1_0}, {14'd0, m_opc});
      chk("WriteReg",  {13'd0, bus.mem_WriteReg},  {13'd0, m_wreg});
      chk("mem_valid", {15'd0, bus.mem_valid}, {15'd0, m_valid});
      chk("mem_Rd",    {15'd0, bus.mem_Rd},
          {15'd0, m_first && m_flags[6] && !m_flags[5]});
      chk("mem_Wr",    {15'd0, bus.mem_Wr}, {15'd0, m_first && m_flags[5]});
      chk("load_data", bus.mem_load_data, m_load);
      chk("pipe_stall", {15'd0, bus.pipe_stall}, {15'd0, m_busy && !bus.dmem_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic bubble();
    bus.ex_valid = 0; bus.flush = 0;
    bus.ex_ALU_Out = 0; bus.ex_readData2 = 0; bus.ex_PCAdd2 = 0; bus.ex_PCImmAdd = 0;
    bus.ex_MSB = 0; bus.ex_Zero = 0; bus.ex_DMemEn = 0; bus.ex_DMemWrite = 0;
    bus.ex_DMemDump = 0; bus.ex_PCImm = 0; bus.ex_PCSrc = 0; bus.ex_Jump = 0;
    bus.ex_RegWrite = 0; bus.ex_OpCode1_0 = 0; bus.ex_WriteReg = 0;
    bus.dmem_stall = 0; bus.dmem_done = 0; bus.dmem_data = 0;
  endtask

  task automatic set_op(input bit v, input bit en, input bit wr,
                        input logic [15:0] alu, input logic [15:0] d2);
    bus.ex_valid = v; bus.ex_DMemEn = en; bus.ex_DMemWrite = wr;
    bus.ex_ALU_Out = alu; bus.ex_readData2 = d2;
    bus.ex_RegWrite = 1; bus.ex_WriteReg = 3'd5; bus.ex_PCAdd2 = 16'h0102;
  endtask

  task automatic randomize_inputs();
    int k;
    bus.ex_valid     = ($urandom_range(9) < 8);
    bus.flush        = ($urandom_range(9) == 0);
    bus.ex_ALU_Out   = 16'($urandom);
    bus.ex_readData2 = 16'($urandom);
    bus.ex_PCAdd2    = 16'($urandom);
    bus.ex_PCImmAdd  = 16'($urandom);
    {bus.ex_MSB, bus.ex_Zero, bus.ex_DMemDump, bus.ex_PCImm, bus.ex_PCSrc,
     bus.ex_Jump, bus.ex_RegWrite} = 7'($urandom);
    bus.ex_OpCode1_0 = 2'($urandom);
    bus.ex_WriteReg  = 3'($urandom);
    k = $urandom_range(9);
    bus.ex_DMemEn    = (k < 5);
    bus.ex_DMemWrite = (k >= 3 && k <= 5);
    bus.dmem_stall   = 1'($urandom);
    bus.dmem_done    = ($urandom_range(2) == 0);
    bus.dmem_data    = 16'($urandom);
    rst              = ($urandom_range(99) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rd0;
    n_checks = 0; n_err = 0; rd_count = 0;
    rst = 1;
    bubble();
    tick(); tick();
    // Reset state
    chk("rst mem_valid", {15'd0, bus.mem_valid}, 16'd0);
    chk("rst load_data", bus.mem_load_data, 16'd0);
    chk("rst pipe_stall", {15'd0, bus.pipe_stall}, 16'd0);
    chk("rst Rd/Wr", {14'd0, bus.mem_Rd, bus.mem_Wr}, 16'd0);
    rst = 0;

    // Plain ALU op passes straight through
    set_op(1, 0, 0, 16'h1357, 16'h0000);
    tick();
    bubble(); #1;
    chk("alu ALU_Out", bus.mem_ALU_Out, 16'h1357);
    chk("alu valid", {15'd0, bus.mem_valid}, 16'd1);
    chk("alu stall", {15'd0, bus.pipe_stall}, 16'd0);
    tick();
    chk("bubble valid", {15'd0, bus.mem_valid}, 16'd0);
    chk("bubble RegWrite", {15'd0, bus.mem_RegWrite}, 16'd0);

    // Load hitting in the strobe cycle
    set_op(1, 1, 0, 16'h0040, 16'h0000);
    tick();
    bubble(); bus.dmem_done = 1; bus.dmem_data = 16'hBEEF; #1;
    chk("hit Rd", {15'd0, bus.mem_Rd}, 16'd1);
    chk("hit stall", {15'd0, bus.pipe_stall}, 16'd0);
    chk("hit addr", bus.mem_ALU_Out, 16'h0040);
    tick();
    bus.dmem_done = 0; #1;
    chk("hit load_data", bus.mem_load_data, 16'hBEEF);
    chk("hit Rd drop", {15'd0, bus.mem_Rd}, 16'd0);

    // Store completing three cycles after the strobe
    set_op(1, 1, 1, 16'h0022, 16'h1234);
    tick();
    bubble(); bus.ex_valid = 1; bus.ex_ALU_Out = 16'hFFFF; bus.ex_DMemEn = 1; #1;
    chk("st Wr", {15'd0, bus.mem_Wr}, 16'd1);
    chk("st Rd", {15'd0, bus.mem_Rd}, 16'd0);
    chk("st stall0", {15'd0, bus.pipe_stall}, 16'd1);
    tick(); #1;
    chk("st Wr drop", {15'd0, bus.mem_Wr}, 16'd0);
    chk("st stall1", {15'd0, bus.pipe_stall}, 16'd1);
    chk("st addr held", bus.mem_ALU_Out, 16'h0022);
    chk("st data held", bus.mem_readData2, 16'h1234);
    tick(); #1;
    chk("st stall2", {15'd0, bus.pipe_stall}, 16'd1);
    tick();
    bus.dmem_done = 1; #1;
    chk("st stall3", {15'd0, bus.pipe_stall}, 16'd0);
    chk("st addr done", bus.mem_ALU_Out, 16'h0022);
    tick();
    bubble();

    // Flush while idle kills the load
    set_op(1, 1, 0, 16'h0044, 16'h0000); bus.flush = 1;
    tick();
    bubble(); #1;
    chk("flush valid", {15'd0, bus.mem_valid}, 16'd0);
    chk("flush stall", {15'd0, bus.pipe_stall}, 16'd0);
    tick();
    chk("flush Rd", {15'd0, bus.mem_Rd}, 16'd0);

    // Flush while waiting is ignored
    set_op(1, 1, 0, 16'h0050, 16'h0000);
    tick();
    bubble(); bus.flush = 1;
    tick(); #1;
    chk("wflush valid", {15'd0, bus.mem_valid}, 16'd1);
    chk("wflush stall", {15'd0, bus.pipe_stall}, 16'd1);
    bus.dmem_done = 1; bus.dmem_data = 16'hCAFE;
    tick();
    bubble(); #1;
    chk("wflush load", bus.mem_load_data, 16'hCAFE);

    // Reset while waiting, late completion ignored
    set_op(1, 1, 0, 16'h0060, 16'h0000);
    tick();
    bubble();
    tick();
    rst = 1;
    tick();
    chk("rstw ALU_Out", bus.mem_ALU_Out, 16'h0000);
    chk("rstw load", bus.mem_load_data, 16'h0000);
    rst = 0; bus.dmem_done = 1; bus.dmem_data = 16'h5555;
    tick();
    bus.dmem_done = 0; #1;
    chk("rstw late load", bus.mem_load_data, 16'h0000);
    chk("rstw valid", {15'd0, bus.mem_valid}, 16'd0);
    chk("rstw stall", {15'd0, bus.pipe_stall}, 16'd0);
    chk("rstw Rd/Wr", {14'd0, bus.mem_Rd, bus.mem_Wr}, 16'd0);

    // Two back-to-back hitting loads
    rd0 = rd_count;
    set_op(1, 1, 0, 16'h0010, 16'h0000);
    tick();
    set_op(1, 1, 0, 16'h0012, 16'h0000); bus.dmem_done = 1; bus.dmem_data = 16'h1111; #1;
    chk("b2b Rd1", {15'd0, bus.mem_Rd}, 16'd1);
    tick();
    bus.dmem_done = 0; #1;
    chk("b2b load1", bus.mem_load_data, 16'h1111);
    tick();
    bus.dmem_done = 1; bus.dmem_data = 16'h2222; #1;
    chk("b2b Rd2", {15'd0, bus.mem_Rd}, 16'd1);
    chk("b2b addr2", bus.mem_ALU_Out, 16'h0012);
    tick();
    bubble(); #6;
    chk("b2b load2", bus.mem_load_data, 16'h2222);
    chk("b2b pulses", 16'(rd_count - rd0), 16'd2);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
    end
    bubble(); rst = 0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
